// File: rtl/instr_sequencer.sv
// Instruction issue sequencer: program store, PC stepping and a valid/ready issue port.
// Optional feature macro INSTR_SEQ_LOOP_EN: the program restarts at address 0 after its last accept.
module instr_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               start,
  input  logic               halt_req,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               decoding,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE,
    S_ERROR
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W:0]      len_q, len_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [INSTR_W-1:0]   store_q [DEPTH];
  logic [INSTR_W-1:0]   rd_word;
  logic                 ctrl_idle;
  logic                 accept;
  logic                 last;

  assign rd_word   = store_q[pc_q];
  assign ctrl_idle = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign accept    = (state_q == S_ISSUE) && instr_ready;
  // len may equal DEPTH, so the compare is done one bit wider than pc.
  assign last      = (({1'b0, pc_q} + (ADDR_W + 1)'(1)) == len_q);

  // Store is only writable while no run is in progress; contents survive reset.
  always_ff @(posedge clock) begin
    if (prog_we && ctrl_idle) begin
      store_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          len_d   = prog_len;
          pc_d    = '0;
          state_d = (prog_len == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        // Halt is checked before the read so a halted run never faults.
        if (halt_req) begin
          state_d = S_IDLE;
        end else if (rd_word[6:4] != 3'b000) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_ISSUE;
          instr_d = rd_word;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          if (last) begin
`ifdef INSTR_SEQ_LOOP_EN
            pc_d    = '0;
            state_d = halt_req ? S_IDLE : S_FETCH;
`else
            state_d = S_DONE;
`endif
          end else begin
            pc_d    = pc_q + ADDR_W'(1);
            state_d = halt_req ? S_IDLE : S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instruction = instr_q;
  assign instr_valid = (state_q == S_ISSUE);
  assign decoding    = (state_q == S_ISSUE);
  assign pc          = pc_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);
  assign illegal     = (state_q == S_ERROR);

endmodule
